i2s_transmitter: RTL and testbench
==================================

I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 18: bits per channel sample; legal range 1..31.
REQ-002 Parameter BCLK_DIV, default 4: clk cycles per BCLK half-period; minimum 1.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  request to transmit frames.
REQ-006 in_valid  input  1  stereo sample pair offered.
REQ-007 in_ready  output  1  holding buffer can accept a pair.
REQ-008 in_left  input  SAMPLE_WIDTH  left sample, two's complement.
REQ-009 in_right  input  SAMPLE_WIDTH  right sample, two's complement.
REQ-010 BCLK  output  1  I2S bit clock.
REQ-011 LRCLK  output  1  I2S word select: 0 = left slot, 1 = right slot.
REQ-012 SDATA  output  1  I2S serial data, MSB first.
REQ-013 underrun  output  1  one-cycle pulse when a frame starts with the buffer empty.
REQ-014 busy  output  1  high while the state is RUN.

Function
REQ-015 Handshake: transfer occurs on a cycle with in_valid && in_ready; the transferred pair is captured into a one-frame holding buffer.
REQ-016 in_ready SHALL equal the registered inverse of buf_full, with no combinational path from in_valid.
REQ-017 States: IDLE and RUN.
- IDLE -> RUN on the cycle after enable && buf_full.
- RUN -> IDLE at a frame boundary when enable = 0.
REQ-018 In IDLE, outputs SHALL hold BCLK = 0, LRCLK = 1, SDATA = 0.
REQ-019 Entering RUN:
- load the buffer into the shift registers and clear buf_full;
- frame bit k = 0, LRCLK = 0, SDATA = 0, BCLK = 0, divider = 0.
REQ-020 BCLK SHALL toggle when the divider reaches BCLK_DIV-1; the BCLK period is 2*BCLK_DIV clk cycles.
REQ-021 Falling tick (BCLK 1 -> 0), same clk edge:
- k advances mod 64;
- LRCLK = (k >= 32);
- SDATA is updated.
REQ-022 SDATA at frame bit k:
- left[SAMPLE_WIDTH-k] for 1 <= k <= SAMPLE_WIDTH;
- right[SAMPLE_WIDTH-(k-32)] for 33 <= k <= 32+SAMPLE_WIDTH;
- 0 otherwise.
This gives standard I2S one-bit delay in 32-bit slots.
REQ-023 LRCLK and SDATA SHALL change only on falling ticks, so they are stable across every rising BCLK edge.
REQ-024 Frame boundary (falling tick with k 63 -> 0):
- if enable = 0: go to IDLE with BCLK = 0;
- else if buf_full: load the buffer and clear buf_full;
- else: underrun handling per REQ-031/032 and assert underrun.
REQ-025 A transfer on the same cycle as a frame-boundary load while buf_full = 0 counts as an underrun; that pair is held and sent in the next frame.
REQ-026 A transfer is impossible on a load cycle with buf_full = 1 (in_ready = 0); buf_full is clear on the following cycle.
REQ-027 Deasserting enable mid-frame SHALL complete the current frame (through k = 63) before IDLE.
REQ-028 busy SHALL be high in RUN, including the final frame.

Reset
REQ-029 On reset (any cycle, including mid-frame), the next-cycle values SHALL be:
- state IDLE, buf_full = 0, in_ready = 1;
- BCLK = 0, LRCLK = 1, SDATA = 0, underrun = 0, busy = 0;
- k = 0, divider = 0, shift registers and last-frame register = 0.
REQ-030 Reset SHALL dominate enable and in_valid on the same cycle; no transfer occurs.

Configuration
REQ-031 With macro I2S_TX_REPEAT_EN defined, an underrun frame SHALL retransmit the last transmitted pair (zeros if none since reset).
REQ-032 Without I2S_TX_REPEAT_EN, an underrun frame SHALL transmit all-zero samples and the last-frame register is not built.
REQ-033 Underrun pulse, handshake and timing SHALL be identical in both builds.

Verification (BCLK_DIV = 2, SAMPLE_WIDTH = 18)
REQ-034 Reset held 3 cycles with enable = 1, in_valid = 1 -> during and after: BCLK = 0, LRCLK = 1, SDATA = 0, in_ready = 1, busy = 0, no transfer.
REQ-035 Send pair left = 18'h20001, right = 18'h3FFFF, enable = 1 -> at rising BCLK edges:
- LRCLK = 0 for k = 0..31; SDATA = 1 at k = 1 and k = 18, 0 at k = 0, 2..17 and 19..31;
- LRCLK = 1 for k = 32..63; SDATA = 1 at k = 33..50, 0 elsewhere;
- BCLK period = 4 clk.
REQ-036 Back-pressure: three pairs offered back-to-back -> first accepted, starts RUN; second fills buffer; in_ready = 0 until the second frame-boundary load, then third accepted.
REQ-037 No second pair before k 63 -> 0 -> one-cycle underrun pulse; frame 2 carries zeros (no macro) or repeats frame 1 (I2S_TX_REPEAT_EN).
REQ-038 enable dropped at k = 10 -> frame completes through k = 63, then IDLE with BCLK = 0, LRCLK = 1, busy = 0.
REQ-039 Reset asserted at k = 40 -> next cycle all outputs at reset values; buffered pair discarded; a new pair restarts from k = 0.

Source files
------------

// File: rtl/i2s_transmitter_if.sv
// ============================================================================
// Module   : i2s_transmitter_if
// Brief    : Valid/ready stereo sample handshake for the I2S transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2s_transmitter_if #(
  parameter int SAMPLE_WIDTH = 18
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SAMPLE_WIDTH-1:0] in_left;
  logic [SAMPLE_WIDTH-1:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input in_ready);
  modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

`default_nettype wire

// File: rtl/i2s_transmitter.sv
// ============================================================================
// Module   : i2s_transmitter
// Brief    : I2S master transmitter, 64-bit frames with 32-bit slots, one-frame
//            holding buffer. Define I2S_TX_REPEAT_EN to resend the last pair on
//            underrun instead of zeros.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_transmitter #(
  parameter int SAMPLE_WIDTH = 18,
  parameter int BCLK_DIV     = 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         enable,
  i2s_transmitter_if.slave  in_bus,
  output logic              BCLK,
  output logic              LRCLK,
  output logic              SDATA,
  output logic              underrun,
  output logic              busy
);

  localparam logic [0:0] c_IDLE    = 1'b0;
  localparam logic [0:0] c_RUN     = 1'b1;
  localparam int         c_DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(BCLK_DIV - 1);

  logic [0:0]              r_state;
  logic                    r_buf_full;
  logic                    r_in_ready;
  logic [SAMPLE_WIDTH-1:0] r_buf_l;
  logic [SAMPLE_WIDTH-1:0] r_buf_r;
  logic [SAMPLE_WIDTH-1:0] r_sh_l;
  logic [SAMPLE_WIDTH-1:0] r_sh_r;
  logic [5:0]              r_k;
  logic [c_DIV_W-1:0]      r_div;
  logic                    r_bclk;
  logic                    r_lrclk;
  logic                    r_sdata;
  logic                    r_underrun;

  logic                    w_xfer;
  logic                    w_tick;
  logic                    w_boundary;
  logic                    w_start;
  logic                    w_reload;
  logic                    w_load_buf;
  logic [5:0]              w_k_next;
  logic                    w_in_slot;
  logic [SAMPLE_WIDTH-1:0] w_fill_l;
  logic [SAMPLE_WIDTH-1:0] w_fill_r;
  logic [SAMPLE_WIDTH-1:0] w_frame_l;
  logic [SAMPLE_WIDTH-1:0] w_frame_r;

  assign w_xfer     = in_bus.in_valid & r_in_ready;
  assign w_tick     = (r_state == c_RUN) && (r_div == c_DIV_MAX);
  assign w_boundary = w_tick && r_bclk && (r_k == 6'd63);
  assign w_start    = (r_state == c_IDLE) && enable && r_buf_full;
  assign w_reload   = w_boundary && enable;
  assign w_load_buf = (w_start || w_reload) && r_buf_full;
  assign w_k_next   = r_k + 6'd1;
  // Slot-relative bit 1..SAMPLE_WIDTH carries data; bit 0 is the I2S delay bit.
  assign w_in_slot  = (w_k_next[4:0] != 5'd0) && (int'(w_k_next[4:0]) <= SAMPLE_WIDTH);

`ifdef I2S_TX_REPEAT_EN
  logic [SAMPLE_WIDTH-1:0] r_last_l;
  logic [SAMPLE_WIDTH-1:0] r_last_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_l <= '0;
      r_last_r <= '0;
    end else if (w_load_buf) begin
      r_last_l <= r_buf_l;
      r_last_r <= r_buf_r;
    end
  end

  assign w_fill_l = r_last_l;
  assign w_fill_r = r_last_r;
`else
  assign w_fill_l = '0;
  assign w_fill_r = '0;
`endif

  assign w_frame_l = r_buf_full ? r_buf_l : w_fill_l;
  assign w_frame_r = r_buf_full ? r_buf_r : w_fill_r;

  // in_ready mirrors ~buf_full from a register, so it never depends on in_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_full <= 1'b0;
      r_in_ready <= 1'b1;
      r_buf_l    <= '0;
      r_buf_r    <= '0;
    end else if (w_load_buf) begin
      r_buf_full <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (w_xfer) begin
      r_buf_full <= 1'b1;
      r_in_ready <= 1'b0;
      r_buf_l    <= in_bus.in_left;
      r_buf_r    <= in_bus.in_right;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_sh_l     <= '0;
      r_sh_r     <= '0;
      r_k        <= '0;
      r_div      <= '0;
      r_bclk     <= 1'b0;
      r_lrclk    <= 1'b1;
      r_sdata    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (r_state == c_IDLE) begin
        r_k     <= '0;
        r_div   <= '0;
        r_bclk  <= 1'b0;
        r_lrclk <= 1'b1;
        r_sdata <= 1'b0;
        if (w_start) begin
          r_state <= c_RUN;
          r_lrclk <= 1'b0;
          r_sh_l  <= r_buf_l;
          r_sh_r  <= r_buf_r;
        end
      end else if (w_tick) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
        // LRCLK/SDATA move only on the falling edge of BCLK.
        if (r_bclk) begin
          r_k <= w_k_next;
          if (w_boundary) begin
            r_sdata <= 1'b0;
            if (!enable) begin
              r_state <= c_IDLE;
              r_lrclk <= 1'b1;
            end else begin
              r_lrclk    <= 1'b0;
              r_sh_l     <= w_frame_l;
              r_sh_r     <= w_frame_r;
              r_underrun <= ~r_buf_full;
            end
          end else begin
            r_lrclk <= w_k_next[5];
            if (w_in_slot && !w_k_next[5]) begin
              r_sdata <= r_sh_l[SAMPLE_WIDTH-1];
              r_sh_l  <= r_sh_l << 1;
            end else if (w_in_slot && w_k_next[5]) begin
              r_sdata <= r_sh_r[SAMPLE_WIDTH-1];
              r_sh_r  <= r_sh_r << 1;
            end else begin
              r_sdata <= 1'b0;
            end
          end
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign in_bus.in_ready = r_in_ready;
  assign BCLK            = r_bclk;
  assign LRCLK           = r_lrclk;
  assign SDATA           = r_sdata;
  assign underrun        = r_underrun;
  assign busy            = (r_state == c_RUN);

endmodule

`default_nettype wire

// File: tb/tb_i2s_transmitter.sv
// ============================================================================
// Module   : tb_i2s_transmitter
// Brief    : Scoreboard bench for i2s_transmitter (SAMPLE_WIDTH 18, BCLK_DIV 2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2s_transmitter;

  localparam int W     = 18;
  localparam int DIV   = 2;
  localparam int LIMIT = 2000;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;
  logic BCLK, LRCLK, SDATA, underrun, busy;

  i2s_transmitter_if #(.SAMPLE_WIDTH(W)) bus ();

  i2s_transmitter #(.SAMPLE_WIDTH(W), .BCLK_DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .in_bus   (bus),
    .BCLK     (BCLK),
    .LRCLK    (LRCLK),
    .SDATA    (SDATA),
    .underrun (underrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame: slot bit 0 is the delay bit, MSB follows at bit 1.
  function automatic logic [63:0] frame_bits(input logic [W-1:0] l, input logic [W-1:0] r);
    logic [63:0] f;
    f = '0;
    for (int k = 1; k <= W; k++) begin
      f[k]      = l[W-k];
      f[32 + k] = r[W-k];
    end
    return f;
  endfunction

  int mon_k       = 0;
  int frames_done = 0;
  int ur_pulses   = 0;
  int ur_cycles   = 0;
  int since_rise  = 0;
  logic prev_bclk = 1'b0;
  logic prev_ur   = 1'b0;
  logic [63:0] cap_sd = '0;
  logic [63:0] cap_lr = '0;

  initial forever begin
    logic [63:0] exp_sd;
    @(posedge clk);
    #1;
    if (underrun === 1'b1) ur_cycles++;
    if (underrun === 1'b1 && prev_ur !== 1'b1) ur_pulses++;
    prev_ur = underrun;
    since_rise++;
    if (busy !== 1'b1) begin
      mon_k = 0;
    end else if (BCLK === 1'b1 && prev_bclk !== 1'b1) begin
      if (mon_k == 5) check("bclk_period", 64'(since_rise), 64'(DIV * 2));
      cap_sd[mon_k] = SDATA;
      cap_lr[mon_k] = LRCLK;
      since_rise = 0;
      mon_k++;
      if (mon_k == 64) begin
        check("sb_avail", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          exp_sd = sb_q.pop_front();
          check("frame_sdata", cap_sd, exp_sd);
        end
        check("frame_lrclk", cap_lr, 64'hFFFF_FFFF_0000_0000);
        frames_done++;
        mon_k = 0;
      end
    end
    prev_bclk = BCLK;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_pair(input logic [W-1:0] l, input logic [W-1:0] r, input bit expect_frame);
    int c;
    c = 0;
    bus.in_left  = l;
    bus.in_right = r;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && c < LIMIT) begin
      step(1);
      c++;
    end
    check("accept", 64'(c < LIMIT), 64'd1);
    step(1);
    bus.in_valid = 1'b0;
    if (expect_frame) sb_q.push_back(frame_bits(l, r));
  endtask

  task automatic wait_k(input int n);
    int c;
    c = 0;
    while (!(busy === 1'b1 && mon_k == n) && c < LIMIT) begin
      step(1);
      c++;
    end
    check("wait_k", 64'(c < LIMIT), 64'd1);
  endtask

  task automatic wait_frames(input int n);
    int c;
    c = 0;
    while (frames_done < n && c < 4 * LIMIT) begin
      step(1);
      c++;
    end
    check("wait_frames", 64'(c < 4 * LIMIT), 64'd1);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy !== 1'b0 && c < LIMIT) begin
      step(1);
      c++;
    end
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_bclk", 64'(BCLK), 64'd0);
    check("idle_lrclk", 64'(LRCLK), 64'd1);
    check("idle_sdata", 64'(SDATA), 64'd0);
  endtask

  initial begin
    int ur0, urc0, f0;
    logic [63:0] fill;
    bus.in_valid = 1'b0;
    bus.in_left  = '0;
    bus.in_right = '0;

    // Reset dominates enable and in_valid.
    reset = 1'b1;
    enable = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_left  = 18'h12345;
    bus.in_right = 18'h0ABCD;
    repeat (3) begin
      step(1);
      check("rst_bclk", 64'(BCLK), 64'd0);
      check("rst_lrclk", 64'(LRCLK), 64'd1);
      check("rst_sdata", 64'(SDATA), 64'd0);
      check("rst_ready", 64'(bus.in_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    step(5);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_ready", 64'(bus.in_ready), 64'd1);

    // Single frame, enable dropped at k = 10.
    ur0 = ur_pulses;
    send_pair(18'h20001, 18'h3FFFF, 1'b1);
    wait_k(10);
    enable = 1'b0;
    wait_idle();
    check("single_no_underrun", 64'(ur_pulses - ur0), 64'd0);

    // Back-pressure with three pairs.
    enable = 1'b1;
    ur0 = ur_pulses;
    f0 = frames_done;
    send_pair(18'h15555, 18'h2AAAA, 1'b1);
    send_pair(18'h00F0F, 18'h3C3C3, 1'b1);
    check("bp_ready_low", 64'(bus.in_ready), 64'd0);
    check("bp_busy", 64'(busy), 64'd1);
    send_pair(18'h3FFFE, 18'h00001, 1'b1);
    check("bp_third_after_load", 64'(frames_done), 64'(f0 + 1));
    wait_frames(f0 + 2);
    wait_k(10);
    enable = 1'b0;
    wait_idle();
    check("bp_frames", 64'(frames_done), 64'(f0 + 3));
    check("bp_no_underrun", 64'(ur_pulses - ur0), 64'd0);

    // Underrun: one pair, then a fill frame.
    enable = 1'b1;
    ur0 = ur_pulses;
    urc0 = ur_cycles;
    f0 = frames_done;
    send_pair(18'h2468A, 18'h13579, 1'b1);
`ifdef I2S_TX_REPEAT_EN
    fill = frame_bits(18'h2468A, 18'h13579);
`else
    fill = '0;
`endif
    sb_q.push_back(fill);
    wait_frames(f0 + 1);
    wait_k(10);
    enable = 1'b0;
    wait_idle();
    check("underrun_pulses", 64'(ur_pulses - ur0), 64'd1);
    check("underrun_width", 64'(ur_cycles - urc0), 64'd1);

    // Reset at k = 40 with a pair buffered.
    enable = 1'b1;
    send_pair(18'h11111, 18'h22222, 1'b1);
    send_pair(18'h33333, 18'h04444, 1'b1);
    wait_k(41);
    reset = 1'b1;
    step(1);
    check("midrst_bclk", 64'(BCLK), 64'd0);
    check("midrst_lrclk", 64'(LRCLK), 64'd1);
    check("midrst_sdata", 64'(SDATA), 64'd0);
    check("midrst_underrun", 64'(underrun), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(bus.in_ready), 64'd1);
    sb_q.delete();
    reset = 1'b0;
    step(10);
    check("midrst_discard", 64'(busy), 64'd0);
    send_pair(18'h2DEAD, 18'h1BEEF, 1'b1);
    wait_k(10);
    enable = 1'b0;
    wait_idle();

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
